mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch port and a data port.
// Round-robin on conflict; each access holds the memory for WAIT_CYCLES+1 cycles.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int DW          = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_ownerData;
  logic          r_lastData;
  logic          r_ifGnt;
  logic          r_ifDone;
  logic [DW-1:0] r_ifRdata;
  logic          r_dGnt;
  logic          r_dDone;
  logic [DW-1:0] r_dRdata;
  logic          r_memEn;
  logic          r_memWe;
  logic [DW-1:0] r_memAddr;
  logic [DW-1:0] r_memWdata;
  logic          r_busy;

  state_t        w_nextState;
  logic [3:0]    w_nextCnt;
  logic          w_nextOwnerData;
  logic          w_nextLastData;
  logic          w_nextIfGnt;
  logic          w_nextIfDone;
  logic [DW-1:0] w_nextIfRdata;
  logic          w_nextDGnt;
  logic          w_nextDDone;
  logic [DW-1:0] w_nextDRdata;
  logic          w_nextMemEn;
  logic          w_nextMemWe;
  logic [DW-1:0] w_nextMemAddr;
  logic [DW-1:0] w_nextMemWdata;
  logic          w_pickData;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_nextState     = r_state;
    w_nextCnt       = r_cnt;
    w_nextOwnerData = r_ownerData;
    w_nextLastData  = r_lastData;
    w_nextIfGnt     = 1'b0;
    w_nextIfDone    = 1'b0;
    w_nextIfRdata   = r_ifRdata;
    w_nextDGnt      = 1'b0;
    w_nextDDone     = 1'b0;
    w_nextDRdata    = r_dRdata;
    w_nextMemEn     = r_memEn;
    w_nextMemWe     = r_memWe;
    w_nextMemAddr   = r_memAddr;
    w_nextMemWdata  = r_memWdata;
    w_pickData      = d_req && (!if_req || !r_lastData);

    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_nextState     = ACCESS;
          w_nextCnt       = 4'd0;
          w_nextOwnerData = w_pickData;
          w_nextLastData  = w_pickData;
          w_nextIfGnt     = !w_pickData;
          w_nextDGnt      = w_pickData;
          w_nextMemEn     = 1'b1;
          w_nextMemWe     = w_pickData && d_we;
          w_nextMemAddr   = w_pickData ? d_addr : if_addr;
          w_nextMemWdata  = w_pickData ? d_wdata : '0;
        end
      end
      ACCESS: begin
        if (r_cnt == LastCnt) begin
          w_nextState = DONE;
          w_nextMemEn = 1'b0;
          w_nextMemWe = 1'b0;
          if (r_ownerData) begin
            w_nextDRdata = mem_rdata;
            w_nextDDone  = 1'b1;
          end else begin
            w_nextIfRdata = mem_rdata;
            w_nextIfDone  = 1'b1;
          end
        end else begin
          w_nextCnt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Reset aborts any transaction in flight; the fetch port counts as last granted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ownerData <= 1'b0;
      r_lastData  <= 1'b0;
      r_ifGnt     <= 1'b0;
      r_ifDone    <= 1'b0;
      r_ifRdata   <= '0;
      r_dGnt      <= 1'b0;
      r_dDone     <= 1'b0;
      r_dRdata    <= '0;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_ownerData <= w_nextOwnerData;
      r_lastData  <= w_nextLastData;
      r_ifGnt     <= w_nextIfGnt;
      r_ifDone    <= w_nextIfDone;
      r_ifRdata   <= w_nextIfRdata;
      r_dGnt      <= w_nextDGnt;
      r_dDone     <= w_nextDDone;
      r_dRdata    <= w_nextDRdata;
      r_memEn     <= w_nextMemEn;
      r_memWe     <= w_nextMemWe;
      r_memAddr   <= w_nextMemAddr;
      r_memWdata  <= w_nextMemWdata;
      r_busy      <= (w_nextState != IDLE);
    end
  end

  assign if_gnt    = r_ifGnt;
  assign if_done   = r_ifDone;
  assign if_rdata  = r_ifRdata;
  assign d_gnt     = r_dGnt;
  assign d_done    = r_dDone;
  assign d_rdata   = r_dRdata;
  assign mem_en    = r_memEn;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign busy      = r_busy;

endmodule
